// File: rtl/mac_seq_ctrl_pkg.sv
// mac_seq_ctrl_pkg: FSM states, datapath widths (16/28/33) and sat28/sat16 saturation helpers
package mac_seq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int DATA_W = 16;
  localparam int ACC_W = 28;
  localparam int P_W = 33;
  function automatic logic signed [ACC_W-1:0] sat28(input logic signed [P_W-1:0] p);
    return (&p[P_W-1:ACC_W-1] || ~|p[P_W-1:ACC_W-1]) ? p[ACC_W-1:0] : {p[P_W-1], {(ACC_W-1){~p[P_W-1]}}};
  endfunction
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    return (&v[ACC_W-1:DATA_W-1] || ~|v[ACC_W-1:DATA_W-1]) ? v[DATA_W-1:0] : {v[ACC_W-1], {(DATA_W-1){~v[ACC_W-1]}}};
  endfunction
endpackage

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences TAPS products through an external P=A*B+C unit (start/bias, in_* stream, mac_* unit, out_*/result/busy), MAC_SEQ_CTRL_RELU_EN clamps result at 0
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int TAPS = 25,
  parameter int MAC_LATENCY = 3,
  parameter int FRAC_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [ACC_W-1:0]  bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] pixel,
  input  logic signed [DATA_W-1:0] weight,
  output logic                     mac_ce,
  output logic                     mac_sclr,
  output logic signed [DATA_W-1:0] mac_a,
  output logic signed [DATA_W-1:0] mac_b,
  output logic signed [ACC_W-1:0]  mac_c,
  input  logic signed [P_W-1:0]    mac_p,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] result,
  output logic                     busy
);
  localparam int TW = $clog2(TAPS + 1);
  localparam int WW = $clog2(MAC_LATENCY + 1);
  state_t state, next;
  logic signed [ACC_W-1:0] acc;
  logic signed [DATA_W-1:0] a_q, b_q, r16;
  logic [TW-1:0] tap;
  logic [WW-1:0] wcnt;
  logic last_tap;
  assign last_tap = tap == TW'(TAPS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    in_ready = 1'b0;
    mac_ce = 1'b0;
    mac_sclr = 1'b0;
    out_valid = 1'b0;
    busy = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        mac_sclr = start && !rst;
        next = start ? ISSUE : IDLE;
      end
      ISSUE: begin
        in_ready = 1'b1;
        mac_ce = in_valid;
        next = in_valid ? WAIT : ISSUE;
      end
      WAIT: begin
        mac_ce = 1'b1;
        next = wcnt != '0 ? WAIT : last_tap ? DONE : ISSUE;
      end
      default: begin
        out_valid = 1'b1;
        next = out_ready ? IDLE : DONE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      tap <= '0;
      wcnt <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (state == IDLE && start) begin
        acc <= bias;
        tap <= '0;
      end
      if (state == ISSUE && in_valid) begin
        a_q <= pixel;
        b_q <= weight;
        wcnt <= WW'(MAC_LATENCY - 1);
      end
      if (state == WAIT) begin
        wcnt <= wcnt - WW'(1);
        if (wcnt == '0) begin
          acc <= sat28(mac_p);
          if (!last_tap) tap <= tap + TW'(1);
        end
      end
    end
  // operands pass straight through while issuing, then hold for the pipeline; acc is stable until capture
  assign mac_a = state == ISSUE ? pixel : a_q;
  assign mac_b = state == ISSUE ? weight : b_q;
  assign mac_c = acc;
  assign r16 = sat16(acc >>> FRAC_BITS);
`ifdef MAC_SEQ_CTRL_RELU_EN
  assign result = out_valid && !r16[DATA_W-1] ? r16 : '0;
`else
  assign result = out_valid ? r16 : '0;
`endif
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed self-checking bench with a behavioural 3-stage multiply-add unit
module tb_mac_seq_ctrl;
  localparam int L = 3;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic signed [27:0] bias = '0;
  logic signed [15:0] pixel = '0, weight = '0;
  logic in_ready, mac_ce, mac_sclr, out_valid, busy;
  logic signed [15:0] mac_a, mac_b, result;
  logic signed [27:0] mac_c;
  logic signed [32:0] mac_p;
  logic signed [32:0] pipe [L];
  int n_chk = 0, n_fail = 0, overlap = 0;
  always #5 clk = ~clk;
  mac_seq_ctrl #(.TAPS(25), .MAC_LATENCY(L), .FRAC_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .pixel(pixel), .weight(weight),
    .mac_ce(mac_ce), .mac_sclr(mac_sclr), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_p(mac_p),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );
  always @(posedge clk)
    if (mac_sclr) for (int i = 0; i < L; i++) pipe[i] <= '0;
    else if (mac_ce) begin
      pipe[0] <= 33'(mac_a) * 33'(mac_b) + 33'(mac_c);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  assign mac_p = pipe[L-1];
  always @(negedge clk) if (in_ready && out_valid) overlap++;
  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  longint res, c2;
  int lat, nvalid, unstable;
  task automatic run(input logic signed [27:0] b, input logic signed [15:0] p, input logic signed [15:0] w,
                     input int stall_tap, input int stall_len, input int hold_len, input bit poke_start);
    int taps = 0, sc = 0;
    bit got_c2 = 0;
    lat = 0; nvalid = 0; unstable = 0; c2 = -1;
    bias = b; pixel = p; weight = w; start = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = poke_start;
    for (int t = 0; t < 1000 && !out_valid; t++) begin
      if (busy) lat++;
      if (in_ready && taps == 1 && !got_c2) begin
        c2 = mac_c;
        got_c2 = 1;
      end
      in_valid = !(in_ready && taps == stall_tap && sc < stall_len);
      if (in_ready && !in_valid) sc++;
      if (in_ready && in_valid) taps++;
      @(negedge clk);
    end
    res = result;
    for (int i = 0; i < hold_len; i++) begin
      if (result !== res || !out_valid) unstable++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (out_valid) nvalid++;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
    repeat (3) begin
      if (out_valid) nvalid++;
      @(negedge clk);
    end
  endtask
  initial begin
    int taps;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {busy, in_ready, out_valid, mac_ce, mac_sclr}, 0);
    check("rst_mac_c", mac_c, 0);
    check("rst_result", result, 0);
    rst = 1'b0;
    @(negedge clk);
    run(28'sd0, 16'sd1, 16'sd256, -1, 0, 0, 1'b0);
    check("basic_result", res, 25);
    check("basic_latency", lat, 100);
    check("basic_nvalid", nvalid, 1);
    check("idle_busy", busy, 0);
    run(28'sd0, 16'sd1, -16'sd256, -1, 0, 0, 1'b0);
`ifdef MAC_SEQ_CTRL_RELU_EN
    check("neg_result", res, 0);
`else
    check("neg_result", res, -25);
`endif
    run(28'sd0, 16'sd32767, 16'sd32767, -1, 0, 0, 1'b0);
    check("sat_acc_after_first", c2, 134217727);
    check("sat_result", res, 32767);
    run(28'sd0, -16'sd32768, 16'sd32767, -1, 0, 0, 1'b0);
    check("negsat_acc_after_first", c2, -134217728);
`ifdef MAC_SEQ_CTRL_RELU_EN
    check("negsat_result", res, 0);
`else
    check("negsat_result", res, -32768);
`endif
    run(28'sd25600, 16'sd1, 16'sd256, -1, 0, 0, 1'b0);
    check("bias_result", res, 125);
    run(28'sd0, 16'sd1, 16'sd256, 3, 5, 10, 1'b1);
    check("stall_result", res, 25);
    check("stall_latency", lat, 105);
    check("stall_stable", unstable, 0);
    check("stall_nvalid", nvalid, 1);
    bias = '0; pixel = 16'sd1; weight = 16'sd256; start = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    taps = 0;
    for (int i = 0; i < 200 && taps < 11; i++) begin
      if (in_ready) taps++;
      @(negedge clk);
    end
    check("abort_in_wait", {busy, in_ready, mac_ce}, 3'b101);
    #2 rst = 1'b1;
    #1;
    check("abort_ctrl", {busy, in_ready, out_valid, mac_ce, mac_sclr}, 0);
    check("abort_operands", {mac_a, mac_b, mac_c}, 0);
    check("abort_result", result, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    run(28'sd0, 16'sd1, 16'sd256, -1, 0, 0, 1'b0);
    check("post_abort_result", res, 25);
    check("post_abort_latency", lat, 100);
    check("no_overlap", overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter TAPS, default 25, meaning products accumulated per result (5x5 kernel).
REQ-002 SHALL have parameter MAC_LATENCY, default 3, meaning cycles from mac_ce-qualified operands to valid mac_p.
REQ-003 SHALL have parameter FRAC_BITS, default 8, meaning the arithmetic right shift applied to the accumulator at output.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: start  in  1  begin a dot product; bias  in  28  signed initial accumulator, sampled with start.
REQ-006 SHALL have ports: in_valid  in  1; in_ready  out  1; pixel  in  16  signed; weight  in  16  signed.
REQ-007 SHALL have ports: mac_ce  out  1; mac_sclr  out  1; mac_a  out  16; mac_b  out  16; mac_c  out  28; mac_p  in  33  (multiply-add unit, P = A*B + C).
REQ-008 SHALL have ports: out_valid  out  1; out_ready  in  1; result  out  16  signed; busy  out  1.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-010 IDLE: busy=0; on start=1 SHALL latch bias into acc, clear tap counter, pulse mac_sclr for 1 cycle, go to ISSUE.
REQ-011 start outside IDLE SHALL be ignored.
REQ-012 ISSUE: in_ready=1; on in_valid&in_ready SHALL drive mac_a=pixel, mac_b=weight, mac_c=acc, mac_ce=1 for that cycle, load wait counter, go to WAIT.
REQ-013 ISSUE with in_valid=0 SHALL hold state, mac_ce=0 (stall, no accumulator change).
REQ-014 WAIT: in_ready=0, mac_ce=1 (pipeline advance) for MAC_LATENCY cycles; on the last cycle SHALL capture sat28(mac_p) into acc.
REQ-015 sat28: mac_p clamped to [-2^27, 2^27-1]; mac_a/mac_b/mac_c SHALL hold their last value in WAIT.
REQ-016 After capture: if tap counter = TAPS-1 go to DONE, else increment tap counter and return to ISSUE.
REQ-017 Throughput SHALL be one tap per MAC_LATENCY+1 cycles when in_valid is held high.
REQ-018 DONE: out_valid=1, result=sat16(acc >>> FRAC_BITS), clamp [-32768, 32767]; held stable until out_ready=1, then go to IDLE.
REQ-019 out_valid and in_ready SHALL never be high simultaneously; busy=1 in ISSUE, WAIT, DONE.
REQ-020 mac_ce SHALL be 0 in IDLE and DONE; mac_sclr SHALL be 0 except the REQ-010 pulse.

Reset
REQ-021 rst=1 SHALL asynchronously force IDLE, acc=0, counters=0, and all outputs to 0, including mid-operation.
REQ-022 First start after reset release SHALL produce a correct result with no residue from an aborted run.

Configuration
REQ-023 With macro MAC_SEQ_CTRL_RELU_EN defined, result SHALL be max(0, sat16 value); without it, result SHALL be the signed sat16 value unchanged.

Structure
REQ-024 Shared package SHALL hold the FSM state enumeration, width constants (16/28/33) and the sat28/sat16 saturation functions.
REQ-025 The multiply-add unit SHALL stay external; no sub-module is required inside mac_seq_ctrl.

Verification
REQ-026 TAPS=25, bias=0, pixel=1, weight=256 every tap -> result=25, exactly one out_valid, 100 cycles start-to-out_valid.
REQ-027 Same stimulus, weight=-256 -> result=-25 without macro; result=0 with MAC_SEQ_CTRL_RELU_EN.
REQ-028 pixel=32767, weight=32767, bias=0 -> acc clamps to 2^27-1 after first capture; result=32767.
REQ-029 in_valid low for 5 cycles at tap 3, out_ready low for 10 cycles in DONE -> result identical to REQ-026; result stable while stalled; start ignored.
REQ-030 rst pulsed during WAIT of tap 10 -> all outputs 0 within the reset cycle; next full run -> result=25.
